// File: rtl/exec_trace_monitor.sv
// rtl/exec_trace_monitor.sv - N-lane EX-stage execution monitor with trace FIFO and halt detection
// Optional feature macro: TRACE_SKIP_BUBBLE_EN (skip records for all-bubble cycles)
module exec_trace_monitor #(
    parameter int NUM_LANES = 2,
    parameter int CYC_W     = 32,
    parameter int CNT_W     = 32,
    parameter int DEPTH     = 16,
    localparam int REC_W    = CYC_W + 1 + 65 * NUM_LANES,
    localparam int LID_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CYC_W-1:0]       max_cycles,
    input  logic [NUM_LANES-1:0]   lane_valid,
    input  logic [32*NUM_LANES-1:0] lane_instr,
    input  logic [32*NUM_LANES-1:0] lane_result,
    input  logic                   stall_in,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [REC_W-1:0]       trace_data,
    output logic [CYC_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]       retired_count,
    output logic [CNT_W-1:0]       stall_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   overflow,
    output logic                   halted,
    output logic [1:0]             halt_cause,
    output logic [LID_W-1:0]       halt_lane,
    output logic                   done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [REC_W-1:0]         mem [DEPTH];
    logic [AW:0]              wr_ptr, rd_ptr;
    logic [REC_W-1:0]         last_pop;
    logic                     fifo_empty, fifo_full;
    logic                     running, has_capture, capture, push, pop, drop;
    logic                     sys_hit, wd_hit, halt_now;
    logic [LID_W-1:0]         sys_lane;
    logic [CNT_W-1:0]         retire_inc;
    logic [CNT_W:0]           retire_sum;
    logic [65*NUM_LANES-1:0]  lane_fields;
    logic [REC_W-1:0]         record;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign trace_valid = !fifo_empty;
    assign trace_data  = fifo_empty ? last_pop : mem[rd_ptr[AW-1:0]];
    assign pop         = trace_valid && trace_ready;
    assign running     = (state == S_RUN);

`ifdef TRACE_SKIP_BUBBLE_EN
    assign has_capture = |lane_valid;
`else
    assign has_capture = 1'b1;
`endif

    // A full FIFO still accepts the push when the head leaves on the same edge
    assign capture = running && has_capture;
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    always_comb begin
        sys_hit     = 1'b0;
        sys_lane    = '0;
        retire_inc  = '0;
        lane_fields = '0;
        // Descending scan so the lowest matching lane is the one left standing
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (lane_valid[i] && (lane_instr[32*i +: 32] == 32'h0000_0073 ||
                                  lane_instr[32*i +: 32] == 32'h0010_0073)) begin
                sys_hit  = 1'b1;
                sys_lane = LID_W'(i);
            end
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            retire_inc = retire_inc + CNT_W'(lane_valid[i]);
            lane_fields[65*i +: 65] = {lane_valid[i], lane_result[32*i +: 32], lane_instr[32*i +: 32]};
        end
    end

    assign record     = {cycle_count, stall_in, lane_fields};
    assign retire_sum = {1'b0, retired_count} + {1'b0, retire_inc};
    assign wd_hit     = running && (max_cycles != '0) && (cycle_count == max_cycles - CYC_W'(1));
    assign halt_now   = running && (sys_hit || wd_hit);
    assign done       = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (halt_now) state_nxt = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            last_pop      <= '0;
            cycle_count   <= '0;
            retired_count <= '0;
            stall_count   <= '0;
            drop_count    <= '0;
            overflow      <= 1'b0;
            halted        <= 1'b0;
            halt_cause    <= 2'd0;
            halt_lane     <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_pop <= mem[rd_ptr[AW-1:0]];
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
            if (running) begin
                if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
                if (stall_in && stall_count != '1) stall_count <= stall_count + 1'b1;
                retired_count <= retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
            end
            if (halt_now) begin
                halted     <= 1'b1;
                halt_cause <= sys_hit ? 2'd1 : 2'd2;
                halt_lane  <= sys_hit ? sys_lane : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= record;
    end
endmodule
